param_updown_counter: RTL and testbench

//  Synchronous, parametrised up/down modulo-N counter. Supports enable, parallel load,

---
 rtl/param_updown_counter_if.sv | 26 ++
 rtl/param_updown_counter.sv | 100 ++++++++++
 tb/tb_param_updown_counter.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/param_updown_counter_if.sv
// Bus bundle for param_updown_counter: control/data inputs and count/status outputs.
interface param_updown_counter_if #(
  parameter int WIDTH = 4
);
  logic             i_en;
  logic             i_up_dn;
  logic             i_load;
  logic [WIDTH-1:0] i_load_val;
  logic             i_clear;
  logic [WIDTH-1:0] o_q;
  logic             o_tc;
  logic             o_wrap;
  logic             o_ovf;

  // Driver side (stimulus / controlling logic)
  modport master (
    output i_en, i_up_dn, i_load, i_load_val, i_clear,
    input  o_q, o_tc, o_wrap, o_ovf
  );

  // Counter side
  modport slave (
    input  i_en, i_up_dn, i_load, i_load_val, i_clear,
    output o_q, o_tc, o_wrap, o_ovf
  );
endinterface

// File: rtl/param_updown_counter.sv
// Parametrised up/down modulo-MODULUS counter with load, clear, wrap/saturate
// selection, terminal-count, wrap-pulse and sticky-overflow status.
// Priority per edge: clear > load > en.
module param_updown_counter #(
  parameter int              WIDTH    = 4,
  parameter longint unsigned MODULUS  = 16,
  parameter bit              SATURATE = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  param_updown_counter_if.slave bus
);

  // Internal arithmetic is one bit wider so MODULUS == 2**WIDTH is representable.
  localparam logic [WIDTH:0] C_MOD = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH:0] C_MAX = (WIDTH+1)'(MODULUS - 1);
  localparam logic [WIDTH:0] C_ONE = (WIDTH+1)'(1);

  logic [WIDTH-1:0] r_q;
  logic             r_wrap;
  logic             r_ovf;

  logic [WIDTH:0]   w_q_ext;
  logic [WIDTH:0]   w_inc;
  logic [WIDTH:0]   w_dec;
  logic [WIDTH:0]   w_load_ext;
  logic             w_at_top;
  logic             w_at_bot;
  logic             w_at_bound;
  logic             w_boundary;
  logic [WIDTH-1:0] w_q_step;
  logic [WIDTH-1:0] w_load_clamped;
  logic             w_unused_msb;

  assign w_q_ext    = {1'b0, r_q};
  assign w_inc      = w_q_ext + C_ONE;
  assign w_dec      = w_q_ext - C_ONE;
  assign w_load_ext = {1'b0, bus.i_load_val};

  // Carry/borrow bits never matter: the boundary compares below stop both before they occur.
  assign w_unused_msb = w_inc[WIDTH] ^ w_dec[WIDTH];

  assign w_at_top   = (w_q_ext == C_MAX);
  assign w_at_bot   = (w_q_ext == '0);
  assign w_at_bound = bus.i_up_dn ? w_at_top : w_at_bot;

  // A boundary event only counts when the enable step actually wins priority.
  assign w_boundary = bus.i_en & ~bus.i_clear & ~bus.i_load & w_at_bound;

  // Out-of-range load values clamp to the top of the count range.
  assign w_load_clamped = (w_load_ext < C_MOD) ? bus.i_load_val : C_MAX[WIDTH-1:0];

  // Next value for an enabled step, including wrap or hold at the boundary.
  always_comb begin
    w_q_step = r_q;
    if (bus.i_up_dn) begin
      if (w_at_top) begin
        w_q_step = SATURATE ? r_q : '0;
      end else begin
        w_q_step = w_inc[WIDTH-1:0];
      end
    end else begin
      if (w_at_bot) begin
        w_q_step = SATURATE ? r_q : C_MAX[WIDTH-1:0];
      end else begin
        w_q_step = w_dec[WIDTH-1:0];
      end
    end
  end

  // Count register and status flags with clear > load > en priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q    <= '0;
      r_wrap <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (bus.i_clear) begin
      r_q    <= '0;
      r_wrap <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (bus.i_load) begin
      r_q    <= w_load_clamped;
      r_wrap <= 1'b0;
    end else if (bus.i_en) begin
      r_q    <= w_q_step;
      r_wrap <= w_boundary & ~SATURATE;
      if (w_boundary) begin
        r_ovf <= 1'b1;
      end
    end else begin
      r_wrap <= 1'b0;
    end
  end

  assign bus.o_q    = r_q;
  assign bus.o_wrap = r_wrap;
  assign bus.o_ovf  = r_ovf;
  assign bus.o_tc   = bus.i_en & w_at_bound;

endmodule

// File: tb/tb_param_updown_counter.sv
// Self-checking bench for param_updown_counter: wrap instance (MODULUS=10)
// and saturate instance, checked through an expected-result queue.
module tb_param_updown_counter;

  typedef struct packed {
    logic [3:0] q;
    logic       wrap;
    logic       ovf;
  } exp_t;

  logic clk;
  logic rst;
  exp_t sb_q[$];
  exp_t got;
  exp_t exp_v;
  int   n_cmp;
  int   n_err;

  param_updown_counter_if #(.WIDTH(4)) ifa ();
  param_updown_counter_if #(.WIDTH(4)) ifb ();

  param_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) u_dut_wrap (
    .clk (clk),
    .rst (rst),
    .bus (ifa.slave)
  );

  param_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b1)) u_dut_sat (
    .clk (clk),
    .rst (rst),
    .bus (ifb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic en, input logic up, input logic ld,
                         input logic [3:0] lv, input logic clr);
    ifa.i_en       = en;
    ifa.i_up_dn    = up;
    ifa.i_load     = ld;
    ifa.i_load_val = lv;
    ifa.i_clear    = clr;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_a(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
    ifb.i_en = 1'b0; ifb.i_up_dn = 1'b1; ifb.i_load = 1'b0;
    ifb.i_load_val = 4'd0; ifb.i_clear = 1'b0;
    tick();
    tick();
    sb_q.push_back('{q: 4'd0, wrap: 1'b0, ovf: 1'b0});
    got = {ifa.o_q, ifa.o_wrap, ifa.o_ovf};
    exp_v = sb_q.pop_front();
    n_cmp++;
    if (got !== exp_v) begin
      n_err++;
      $display("FAIL reset_state: got q=%0d wrap=%b ovf=%b, expected q=%0d wrap=%b ovf=%b",
               got.q, got.wrap, got.ovf, exp_v.q, exp_v.wrap, exp_v.ovf);
    end
    rst = 1'b0;
  endtask

  task automatic test_count_up_wrap();
    for (int i = 0; i < 12; i++) begin
      drive_a(1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
      #1;
      n_cmp++;
      if (ifa.o_tc !== ((i % 10) == 9)) begin
        n_err++;
        $display("FAIL up_tc[%0d]: got tc=%b, expected %b", i, ifa.o_tc, ((i % 10) == 9));
      end
      sb_q.push_back('{q: 4'((i + 1) % 10), wrap: (i == 9), ovf: (i >= 9)});
      tick();
      got = {ifa.o_q, ifa.o_wrap, ifa.o_ovf};
      exp_v = sb_q.pop_front();
      n_cmp++;
      if (got !== exp_v) begin
        n_err++;
        $display("FAIL up_seq[%0d]: got q=%0d wrap=%b ovf=%b, expected q=%0d wrap=%b ovf=%b",
                 i, got.q, got.wrap, got.ovf, exp_v.q, exp_v.wrap, exp_v.ovf);
      end
    end
  endtask

  task automatic test_count_down_wrap();
    exp_t steps[5];
    logic ups[5];
    logic clrs[5];
    steps = '{'{4'd0, 1'b0, 1'b0}, '{4'd9, 1'b1, 1'b1}, '{4'd8, 1'b0, 1'b1},
              '{4'd7, 1'b0, 1'b1}, '{4'd8, 1'b0, 1'b1}};
    ups   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    clrs  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      drive_a(1'b1, ups[i], 1'b0, 4'd0, clrs[i]);
      if (i == 1) begin
        #1;
        n_cmp++;
        if (ifa.o_tc !== 1'b1) begin
          n_err++;
          $display("FAIL down_tc_at_zero: got tc=%b, expected 1", ifa.o_tc);
        end
      end
      sb_q.push_back(steps[i]);
      tick();
      got = {ifa.o_q, ifa.o_wrap, ifa.o_ovf};
      exp_v = sb_q.pop_front();
      n_cmp++;
      if (got !== exp_v) begin
        n_err++;
        $display("FAIL down_seq[%0d]: got q=%0d wrap=%b ovf=%b, expected q=%0d wrap=%b ovf=%b",
                 i, got.q, got.wrap, got.ovf, exp_v.q, exp_v.wrap, exp_v.ovf);
      end
    end
    drive_a(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
  endtask

  task automatic test_saturate();
    ifb.i_clear = 1'b1;
    tick();
    ifb.i_clear = 1'b0;
    for (int i = 0; i < 12; i++) begin
      ifb.i_en    = 1'b1;
      ifb.i_up_dn = 1'b1;
      #1;
      n_cmp++;
      if (ifb.o_tc !== (i >= 9)) begin
        n_err++;
        $display("FAIL sat_tc[%0d]: got tc=%b, expected %b", i, ifb.o_tc, (i >= 9));
      end
      sb_q.push_back('{q: 4'((i + 1 > 9) ? 9 : i + 1), wrap: 1'b0, ovf: (i >= 9)});
      tick();
      got = {ifb.o_q, ifb.o_wrap, ifb.o_ovf};
      exp_v = sb_q.pop_front();
      n_cmp++;
      if (got !== exp_v) begin
        n_err++;
        $display("FAIL sat_seq[%0d]: got q=%0d wrap=%b ovf=%b, expected q=%0d wrap=%b ovf=%b",
                 i, got.q, got.wrap, got.ovf, exp_v.q, exp_v.wrap, exp_v.ovf);
      end
    end
    ifb.i_en = 1'b0;
  endtask

  task automatic test_load();
    logic [3:0] lvs[3];
    logic       ens[3];
    logic [3:0] qs[3];
    lvs = '{4'd7, 4'd12, 4'd3};
    ens = '{1'b0, 1'b0, 1'b1};
    qs  = '{4'd7, 4'd9, 4'd3};
    for (int i = 0; i < 3; i++) begin
      drive_a(ens[i], 1'b1, 1'b1, lvs[i], 1'b0);
      sb_q.push_back('{q: qs[i], wrap: 1'b0, ovf: 1'b1});
      tick();
      got = {ifa.o_q, ifa.o_wrap, ifa.o_ovf};
      exp_v = sb_q.pop_front();
      n_cmp++;
      if (got !== exp_v) begin
        n_err++;
        $display("FAIL load[%0d]: got q=%0d wrap=%b ovf=%b, expected q=%0d wrap=%b ovf=%b",
                 i, got.q, got.wrap, got.ovf, exp_v.q, exp_v.wrap, exp_v.ovf);
      end
    end
    drive_a(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
  endtask

  task automatic test_clear_priority();
    drive_a(1'b0, 1'b1, 1'b1, 4'd9, 1'b0);
    sb_q.push_back('{q: 4'd9, wrap: 1'b0, ovf: 1'b1});
    tick();
    drive_a(1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
    sb_q.push_back('{q: 4'd0, wrap: 1'b1, ovf: 1'b1});
    tick();
    got = {ifa.o_q, ifa.o_wrap, ifa.o_ovf};
    void'(sb_q.pop_front());
    exp_v = sb_q.pop_front();
    n_cmp++;
    if (got !== exp_v) begin
      n_err++;
      $display("FAIL prio_setup: got q=%0d wrap=%b ovf=%b, expected q=%0d wrap=%b ovf=%b",
               got.q, got.wrap, got.ovf, exp_v.q, exp_v.wrap, exp_v.ovf);
    end
    drive_a(1'b1, 1'b1, 1'b1, 4'd5, 1'b1);
    sb_q.push_back('{q: 4'd0, wrap: 1'b0, ovf: 1'b0});
    tick();
    got = {ifa.o_q, ifa.o_wrap, ifa.o_ovf};
    exp_v = sb_q.pop_front();
    n_cmp++;
    if (got !== exp_v) begin
      n_err++;
      $display("FAIL clear_load_en: got q=%0d wrap=%b ovf=%b, expected q=%0d wrap=%b ovf=%b",
               got.q, got.wrap, got.ovf, exp_v.q, exp_v.wrap, exp_v.ovf);
    end
    drive_a(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
  endtask

  task automatic test_async_reset();
    drive_a(1'b0, 1'b1, 1'b1, 4'd9, 1'b0);
    tick();
    drive_a(1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
    tick();
    for (int i = 1; i <= 5; i++) begin
      sb_q.push_back('{q: 4'(i), wrap: 1'b0, ovf: 1'b1});
      tick();
      got = {ifa.o_q, ifa.o_wrap, ifa.o_ovf};
      exp_v = sb_q.pop_front();
      n_cmp++;
      if (got !== exp_v) begin
        n_err++;
        $display("FAIL pre_rst_count[%0d]: got q=%0d wrap=%b ovf=%b, expected q=%0d wrap=%b ovf=%b",
                 i, got.q, got.wrap, got.ovf, exp_v.q, exp_v.wrap, exp_v.ovf);
      end
    end
    #2;
    rst = 1'b1;
    #1;
    sb_q.push_back('{q: 4'd0, wrap: 1'b0, ovf: 1'b0});
    got = {ifa.o_q, ifa.o_wrap, ifa.o_ovf};
    exp_v = sb_q.pop_front();
    n_cmp++;
    if (got !== exp_v) begin
      n_err++;
      $display("FAIL async_rst: got q=%0d wrap=%b ovf=%b, expected q=%0d wrap=%b ovf=%b",
               got.q, got.wrap, got.ovf, exp_v.q, exp_v.wrap, exp_v.ovf);
    end
    #2;
    rst = 1'b0;
    sb_q.push_back('{q: 4'd1, wrap: 1'b0, ovf: 1'b0});
    tick();
    got = {ifa.o_q, ifa.o_wrap, ifa.o_ovf};
    exp_v = sb_q.pop_front();
    n_cmp++;
    if (got !== exp_v) begin
      n_err++;
      $display("FAIL post_rst_first: got q=%0d wrap=%b ovf=%b, expected q=%0d wrap=%b ovf=%b",
               got.q, got.wrap, got.ovf, exp_v.q, exp_v.wrap, exp_v.ovf);
    end
    drive_a(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_count_up_wrap();
    test_count_down_wrap();
    test_saturate();
    test_load();
    test_clear_priority();
    test_async_reset();
    n_cmp++;
    if (sb_q.size() !== 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d leftover entries, expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
